// File: rtl/mem_stage_pkg.sv
// Shared memory-stage types: control word, FSM states,
// bubble constant and the byte-mask helper.
package mem_stage_pkg;

  localparam logic [1:0] FWD_ALU = 2'd0;
  localparam logic [1:0] FWD_BR  = 2'd1;
  localparam logic [1:0] FWD_LD  = 2'd2;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic [2:0] load_funct3;
    logic [2:0] store_funct3;
    logic [1:0] memfwdmux_sel;
  } mem_ctrl_t;

  typedef struct packed {
    logic       ld_reg;
    logic [4:0] rd;
  } wb_ctrl_t;

  typedef struct packed {
    logic        valid_commit;
    logic [31:0] inst;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [31:0] rd_wdata;
    logic [31:0] mem_addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
  } rvfi_t;

  typedef struct packed {
    mem_ctrl_t mem;
    wb_ctrl_t  wb;
    rvfi_t     rvfi;
  } control_word;

  typedef enum logic [1:0] {
    MS_IDLE,
    MS_PASS,
    MS_ACCESS
  } mem_state_e;

  localparam control_word CW_BUBBLE = '{
    mem:  '0,
    wb:   '0,
    rvfi: '{pc_rdata: 32'h4000_0000,
            default:  '0}
  };

  // Misaligned sizes simply lose the bits shifted past lane 3.
  function automatic logic [3:0] size_mask(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic [3:0] m;
    unique case (1'b1)
      (f3[1:0] == 2'b00): m = 4'b0001 << off;
      (f3[1:0] == 2'b01): m = 4'b0011 << off;
      default:            m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_stage_align.sv
// Store lane replication / mask and load lane
// select / extend for the memory stage.
module mem_stage_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  i_st_funct3,
  input  logic [2:0]  i_ld_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_wmask,
  output logic [3:0]  o_rmask,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [31:0] w_rsh;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign o_wmask = size_mask(i_st_funct3, i_off);
  assign o_rmask = size_mask(i_ld_funct3, i_off);
  assign w_rsh   = i_rdata >> {i_off, 3'b000};
  assign w_byte  = w_rsh[7:0];
  assign w_half  = i_off[1] ? i_rdata[31:16]
                            : i_rdata[15:0];

  // Replicate store data so every lane carries it.
  always_comb begin
    o_wdata = i_wdata;
    unique case (1'b1)
      (i_st_funct3[1:0] == 2'b00):
        o_wdata = {4{i_wdata[7:0]}};
      (i_st_funct3[1:0] == 2'b01):
        o_wdata = {2{i_wdata[15:0]}};
      default:
        o_wdata = i_wdata;
    endcase
  end

  // Pick the addressed lane and extend it.
  always_comb begin
    o_rdata = i_rdata;
    unique case (1'b1)
      (i_ld_funct3 == F3_B):
        o_rdata = {{24{w_byte[7]}}, w_byte};
      (i_ld_funct3 == F3_BU):
        o_rdata = {24'b0, w_byte};
      (i_ld_funct3 == F3_H):
        o_rdata = {{16{w_half[15]}}, w_half};
      (i_ld_funct3 == F3_HU):
        o_rdata = {16'b0, w_half};
      default:
        o_rdata = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory stage: one-entry holding register,
// dcache requester, forward value and RVFI fill.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        exe_valid,
  input  control_word ctrl_w_exe,
  input  logic [31:0] alu_out,
  input  logic [31:0] rs2_out,
  input  logic        br_en,
  output logic        mem_rdy,
  output logic [31:0] dmem_address,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [3:0]  dmem_mbe,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        mem_valid,
  output logic [31:0] mem_fwd_data,
  output control_word ctrl_w_mem
);

  mem_state_e  r_state;
  mem_state_e  w_next;
  control_word r_ctrl;
  logic [31:0] r_alu;
  logic [31:0] r_rs2;
  logic        r_br;

  logic        w_acc;
  logic        w_done;
  logic        w_load;
  logic        w_mem_op;
  logic [3:0]  w_wmask;
  logic [3:0]  w_rmask;
  logic [31:0] w_ldata;

  assign w_acc    = (r_state == MS_ACCESS);
  assign w_done   = (r_state == MS_PASS)
                 || (w_acc && dmem_resp);
  assign mem_rdy  = (r_state == MS_IDLE) || w_done;
  assign mem_valid = w_done;
  assign w_load   = exe_valid && mem_rdy;
  assign w_mem_op = ctrl_w_exe.mem.mem_read
                 || ctrl_w_exe.mem.mem_write;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= MS_IDLE;
    else     r_state <= w_next;
  end

  // Refill on completion or when empty; else wait.
  always_comb begin
    w_next = r_state;
    if (mem_rdy) begin
      if (!exe_valid)    w_next = MS_IDLE;
      else if (w_mem_op) w_next = MS_ACCESS;
      else               w_next = MS_PASS;
    end
  end

  // Capture the execute result on handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctrl <= '0;
      r_alu  <= '0;
      r_rs2  <= '0;
      r_br   <= 1'b0;
    end else if (w_load) begin
      r_ctrl <= ctrl_w_exe;
      r_alu  <= alu_out;
      r_rs2  <= rs2_out;
      r_br   <= br_en;
    end
  end

  mem_stage_align u_align (
    .i_st_funct3 (r_ctrl.mem.store_funct3),
    .i_ld_funct3 (r_ctrl.mem.load_funct3),
    .i_off       (r_alu[1:0]),
    .i_wdata     (r_rs2),
    .i_rdata     (dmem_rdata),
    .o_wmask     (w_wmask),
    .o_rmask     (w_rmask),
    .o_wdata     (dmem_wdata),
    .o_rdata     (w_ldata)
  );

  assign dmem_address = {r_alu[31:2], 2'b00};
  assign dmem_read  = w_acc && r_ctrl.mem.mem_read;
  assign dmem_write = w_acc && r_ctrl.mem.mem_write;

  // Byte enables only while a request is out.
  always_comb begin
    dmem_mbe = 4'b0000;
    if (dmem_write)     dmem_mbe = w_wmask;
    else if (dmem_read) dmem_mbe = w_rmask;
  end

  // Forward value mux.
  always_comb begin
    mem_fwd_data = r_alu;
    unique case (r_ctrl.mem.memfwdmux_sel)
      FWD_BR:  mem_fwd_data = {31'b0, r_br};
      FWD_LD:  mem_fwd_data = w_ldata;
      default: mem_fwd_data = r_alu;
    endcase
  end

  // Completed word to writeback, bubble otherwise.
  always_comb begin
    ctrl_w_mem = CW_BUBBLE;
    if (w_done) begin
      ctrl_w_mem = r_ctrl;
      ctrl_w_mem.rvfi.mem_addr  = r_alu;
      ctrl_w_mem.rvfi.rmask     =
        r_ctrl.mem.mem_read ? w_rmask : 4'b0;
      ctrl_w_mem.rvfi.wmask     =
        r_ctrl.mem.mem_write ? w_wmask : 4'b0;
      ctrl_w_mem.rvfi.mem_wdata = dmem_wdata;
      ctrl_w_mem.rvfi.mem_rdata = dmem_rdata;
      ctrl_w_mem.rvfi.rd_wdata  =
        r_ctrl.wb.ld_reg ? mem_fwd_data : 32'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage against a
// transaction-level model of the stage.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int K_ALU = 0;
  localparam int K_BR  = 1;
  localparam int K_LD  = 2;
  localparam int K_ST  = 3;

  typedef struct {
    int          kind;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [31:0] rdata;
    logic [31:0] pc;
    logic        br;
    logic        ld_reg;
    int          dly;
  } tx_t;

  logic        clk;
  logic        rst;
  logic        exe_valid;
  control_word ctrl_w_exe;
  logic [31:0] alu_out;
  logic [31:0] rs2_out;
  logic        br_en;
  logic        mem_rdy;
  logic [31:0] dmem_address;
  logic        dmem_read;
  logic        dmem_write;
  logic [3:0]  dmem_mbe;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic        mem_valid;
  logic [31:0] mem_fwd_data;
  control_word ctrl_w_mem;

  mem_stage dut (
    .clk          (clk),
    .rst          (rst),
    .exe_valid    (exe_valid),
    .ctrl_w_exe   (ctrl_w_exe),
    .alu_out      (alu_out),
    .rs2_out      (rs2_out),
    .br_en        (br_en),
    .mem_rdy      (mem_rdy),
    .dmem_address (dmem_address),
    .dmem_read    (dmem_read),
    .dmem_write   (dmem_write),
    .dmem_mbe     (dmem_mbe),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata),
    .dmem_resp    (dmem_resp),
    .mem_valid    (mem_valid),
    .mem_fwd_data (mem_fwd_data),
    .ctrl_w_mem   (ctrl_w_mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int  n_chk;
  int  n_fail;
  tx_t txq[$];
  tx_t m_tx;
  bit  m_full;
  int  m_cnt;
  int  gap_pct;

  task automatic check(
    input string       tag,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, act, exp);
    end
  endtask

  function automatic int size_of(
    input logic [2:0] f3
  );
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] m_mask(
    input logic [2:0] f3,
    input logic [1:0] o
  );
    int sz;
    int m;
    sz = size_of(f3);
    if (sz == 4) return 4'hF;
    m = ((1 << sz) - 1) << o;
    return m[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(
    input logic [2:0]  f3,
    input logic [31:0] d
  );
    int sz;
    sz = size_of(f3);
    if (sz == 1) return (d & 32'hFF) * 32'h0101_0101;
    if (sz == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(
    input logic [2:0]  f3,
    input logic [1:0]  o,
    input logic [31:0] d
  );
    logic [31:0] b;
    logic [31:0] h;
    b = (d >> (8 * o)) & 32'hFF;
    h = (d >> (16 * (o / 2))) & 32'hFFFF;
    case (f3)
      F3_B:  return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      F3_BU: return b;
      F3_H:  return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
      F3_HU: return h;
      default: return d;
    endcase
  endfunction

  function automatic control_word make_cw(input tx_t t);
    control_word c;
    c = '0;
    c.mem.mem_read  = (t.kind == K_LD);
    c.mem.mem_write = (t.kind == K_ST);
    if (t.kind == K_LD) c.mem.load_funct3  = t.f3;
    if (t.kind == K_ST) c.mem.store_funct3 = t.f3;
    c.mem.memfwdmux_sel = (t.kind == K_BR) ? FWD_BR :
                          (t.kind == K_LD) ? FWD_LD : FWD_ALU;
    c.wb.ld_reg = t.ld_reg;
    c.wb.rd = 5'd1;
    c.rvfi.valid_commit = 1'b1;
    c.rvfi.pc_rdata = t.pc;
    c.rvfi.pc_wdata = t.pc + 32'd4;
    c.rvfi.inst = 32'h0000_0013;
    return c;
  endfunction

  function automatic tx_t mk(
    input int          kind,
    input logic [2:0]  f3,
    input logic [31:0] addr,
    input logic [31:0] rs2,
    input logic [31:0] rdata,
    input int          dly
  );
    tx_t t;
    t.kind = kind;
    t.f3 = f3;
    t.addr = addr;
    t.rs2 = rs2;
    t.rdata = rdata;
    t.dly = dly;
    t.br = 1'b0;
    t.pc = 32'h4000_0100;
    t.ld_reg = (kind != K_ST);
    return t;
  endfunction

  function automatic tx_t rnd_tx();
    tx_t t;
    logic [2:0] ld_f3s [5];
    ld_f3s = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};
    t = mk($urandom_range(0, 3), F3_W, $urandom(),
           $urandom(), $urandom(), $urandom_range(0, 3));
    if (t.kind == K_LD) t.f3 = ld_f3s[$urandom_range(0, 4)];
    if (t.kind == K_ST) t.f3 = 3'($urandom_range(0, 2));
    t.br = 1'($urandom_range(0, 1));
    t.pc = $urandom() & 32'hFFFF_FFFC;
    if (t.kind == K_ALU) t.ld_reg = 1'($urandom_range(0, 1));
    return t;
  endfunction

  task automatic cycle();
    bit          resp;
    bit          done;
    bit          rdy;
    bit          acc;
    logic [31:0] fwd;
    @(posedge clk);
    #1;
    exe_valid = (txq.size() > 0)
             && ($urandom_range(0, 99) >= gap_pct);
    if (exe_valid) begin
      ctrl_w_exe = make_cw(txq[0]);
      alu_out = txq[0].addr;
      rs2_out = txq[0].rs2;
      br_en = txq[0].br;
    end
    acc = m_full && (m_tx.kind >= K_LD);
    if (acc) resp = (m_cnt == m_tx.dly);
    else     resp = 1'($urandom_range(0, 1));
    dmem_resp = resp;
    dmem_rdata = (acc && resp) ? m_tx.rdata : $urandom();
    @(negedge clk);
    done = m_full && (!acc || resp);
    rdy = !m_full || done;
    check("mem_rdy", mem_rdy, rdy);
    check("mem_valid", mem_valid, done);
    check("dmem_read", dmem_read, acc && m_tx.kind == K_LD);
    check("dmem_write", dmem_write, acc && m_tx.kind == K_ST);
    if (acc) begin
      check("dmem_address", dmem_address,
            m_tx.addr & 32'hFFFF_FFFC);
      check("dmem_mbe", dmem_mbe,
            m_mask(m_tx.f3, m_tx.addr[1:0]));
      if (m_tx.kind == K_ST)
        check("dmem_wdata", dmem_wdata,
              m_wdata(m_tx.f3, m_tx.rs2));
    end else begin
      check("dmem_mbe_idle", dmem_mbe, 0);
    end
    if (done) begin
      case (m_tx.kind)
        K_BR:    fwd = {31'b0, m_tx.br};
        K_LD:    fwd = m_load(m_tx.f3, m_tx.addr[1:0],
                              m_tx.rdata);
        default: fwd = m_tx.addr;
      endcase
      check("mem_fwd_data", mem_fwd_data, fwd);
      check("valid_commit", ctrl_w_mem.rvfi.valid_commit, 1);
      check("pc_rdata", ctrl_w_mem.rvfi.pc_rdata, m_tx.pc);
      check("rvfi_mem_addr", ctrl_w_mem.rvfi.mem_addr,
            m_tx.addr);
      check("rmask", ctrl_w_mem.rvfi.rmask,
            (m_tx.kind == K_LD) ?
            m_mask(m_tx.f3, m_tx.addr[1:0]) : 4'b0);
      check("wmask", ctrl_w_mem.rvfi.wmask,
            (m_tx.kind == K_ST) ?
            m_mask(m_tx.f3, m_tx.addr[1:0]) : 4'b0);
      check("rd_wdata", ctrl_w_mem.rvfi.rd_wdata,
            m_tx.ld_reg ? fwd : 32'b0);
      check("ld_reg", ctrl_w_mem.wb.ld_reg, m_tx.ld_reg);
    end else begin
      check("bubble_vc", ctrl_w_mem.rvfi.valid_commit, 0);
      check("bubble_pc", ctrl_w_mem.rvfi.pc_rdata,
            32'h4000_0000);
      check("bubble_ldreg", ctrl_w_mem.wb.ld_reg, 0);
    end
    if (done) m_full = 1'b0;
    else if (acc) m_cnt++;
    if (exe_valid && rdy) begin
      m_tx = txq.pop_front();
      m_full = 1'b1;
      m_cnt = 0;
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((txq.size() > 0 || m_full) && n < budget) begin
      cycle();
      n++;
    end
    if (n >= budget) check("drain_timeout", 1, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdy"}, mem_rdy, 1);
    check({tag, "_valid"}, mem_valid, 0);
    check({tag, "_read"}, dmem_read, 0);
    check({tag, "_write"}, dmem_write, 0);
    check({tag, "_vc"}, ctrl_w_mem.rvfi.valid_commit, 0);
    check({tag, "_pc"}, ctrl_w_mem.rvfi.pc_rdata,
          32'h4000_0000);
  endtask

  initial begin
    tx_t t;
    n_chk = 0;
    n_fail = 0;
    m_full = 1'b0;
    m_cnt = 0;
    gap_pct = 0;
    rst = 1'b1;
    exe_valid = 1'b0;
    ctrl_w_exe = '0;
    alu_out = '0;
    rs2_out = '0;
    br_en = 1'b0;
    dmem_rdata = '0;
    dmem_resp = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst0");
    check("rst0_mbe", dmem_mbe, 0);
    check("rst0_addr", dmem_address, 0);
    check("rst0_fwd", mem_fwd_data, 0);
    rst = 1'b0;

    txq.push_back(mk(K_ALU, F3_W, 32'h1234, 0, 0, 0));
    txq.push_back(mk(K_LD, F3_W, 32'h1000, 0,
                     32'hDEAD_BEEF, 2));
    txq.push_back(mk(K_LD, F3_B, 32'h1003, 0,
                     32'h80FF_0000, 1));
    txq.push_back(mk(K_LD, F3_BU, 32'h1003, 0,
                     32'h80FF_0000, 0));
    txq.push_back(mk(K_ST, F3_H, 32'h2002,
                     32'h0000_ABCD, 0, 1));
    txq.push_back(mk(K_LD, F3_W, 32'h3000, 0,
                     32'h1357_9BDF, 0));
    txq.push_back(mk(K_ALU, F3_W, 32'h5555, 0, 0, 0));
    t = mk(K_BR, F3_W, 32'h0, 0, 0, 0);
    t.br = 1'b1;
    txq.push_back(t);
    txq.push_back(mk(K_LD, F3_W, 32'h4000, 0, 0, 20));
    while (txq.size() > 0 && n_chk < 100000) cycle();
    cycle();
    cycle();
    check("lw_waiting", dmem_read, 1);

    @(posedge clk);
    #1;
    rst = 1'b1;
    exe_valid = 1'b0;
    dmem_resp = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk);
    check("rst_mid_mbe", dmem_mbe, 0);
    rst = 1'b0;
    m_full = 1'b0;
    m_cnt = 0;

    gap_pct = 30;
    for (int i = 0; i < 400; i++) txq.push_back(rnd_tx());
    drain(5000);
    gap_pct = 0;
    for (int i = 0; i < 200; i++) txq.push_back(rnd_tx());
    drain(3000);
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
